// File: rtl/servo_pwm_drive.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_drive
//  Description : Converts the signed PID output into a PWM magnitude and an
//                H-bridge direction bit. Every direction reversal is preceded
//                by one full zero-drive frame. Also issues the one-cycle
//                sample strobe that paces the PID, locked to the PWM frame.
//  Ports       : sclk        - system clock, rising edge
//                rst         - asynchronous active-high reset
//                en          - drive enable; low idles the drive
//                u           - signed controller output (two's complement)
//                pwm         - registered PWM drive
//                dir         - registered direction (1 = negative u)
//                sample_tick - one-cycle pulse, feeds PID enable
//                duty        - duty count applied in the current frame
//                sat         - applied duty was clipped to MAX_DUTY
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_drive #(
    parameter int WIDTH     = 18,
    parameter int PERIOD    = 1000,
    parameter int CNT_WIDTH = 10,
    parameter int MAX_DUTY  = 950,
    parameter int SHIFT     = 0,
    parameter int TICK_DIV  = 1
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] u,
    output logic                    pwm,
    output logic                    dir,
    output logic                    sample_tick,
    output logic [CNT_WIDTH-1:0]    duty,
    output logic                    sat
);

    localparam int FC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Compare width wide enough for both the scaled magnitude and MAX_DUTY.
    localparam int CMP_W = (WIDTH + 1 > CNT_WIDTH + 1) ? WIDTH + 1 : CNT_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] C_LAST     = CNT_WIDTH'(PERIOD - 1);
    localparam logic [FC_W-1:0]      C_FC_LAST  = FC_W'(TICK_DIV - 1);
    localparam logic [CMP_W-1:0]     C_MAX_CMP  = CMP_W'(MAX_DUTY);
    localparam logic [CNT_WIDTH-1:0] C_MAX_DUTY = CNT_WIDTH'(MAX_DUTY);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [FC_W-1:0]      r_frame_cnt;
    logic [0:0]           r_state;
    logic [CNT_WIDTH-1:0] r_duty;
    logic                 r_dir;
    logic                 r_sat;
    logic                 r_pwm;

    logic                 w_boundary;
    logic [WIDTH:0]       w_u_ext;
    logic [WIDTH:0]       w_mag;
    logic [WIDTH:0]       w_scaled;
    logic [CMP_W-1:0]     w_scaled_cmp;
    logic                 w_new_sat;
    logic [CNT_WIDTH-1:0] w_new_duty;
    logic                 w_new_dir;

    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [FC_W-1:0]      w_fc_nxt;
    logic [0:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] w_duty_nxt;
    logic                 w_dir_nxt;
    logic                 w_sat_nxt;
    logic                 w_pwm_nxt;

    assign w_boundary = (r_cnt == C_LAST);

    // Magnitude one bit wider than u so the most negative input does not wrap.
    assign w_u_ext      = {u[WIDTH-1], u};
    assign w_mag        = w_u_ext[WIDTH] ? ((WIDTH + 1)'(0) - w_u_ext) : w_u_ext;
    assign w_scaled     = w_mag >> SHIFT;
    assign w_scaled_cmp = CMP_W'(w_scaled);
    assign w_new_sat    = (w_scaled_cmp > C_MAX_CMP);
    assign w_new_duty   = w_new_sat ? C_MAX_DUTY : w_scaled_cmp[CNT_WIDTH-1:0];
    assign w_new_dir    = u[WIDTH-1];

    always_comb begin
        w_cnt_nxt   = w_boundary ? '0 : r_cnt + CNT_WIDTH'(1);
        w_fc_nxt    = r_frame_cnt;
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_dir_nxt   = r_dir;
        w_sat_nxt   = r_sat;

        if (w_boundary) begin
            w_fc_nxt = (r_frame_cnt == C_FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
            if (!en) begin
                // Disabled: idle the drive but keep the last direction.
                w_duty_nxt  = '0;
                w_sat_nxt   = 1'b0;
                w_state_nxt = ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_new_dir == r_dir) begin
                            w_duty_nxt = w_new_duty;
                            w_sat_nxt  = w_new_sat;
                        end else begin
                            // Reversal requested: spend one frame at zero drive.
                            w_duty_nxt  = '0;
                            w_sat_nxt   = 1'b0;
                            w_state_nxt = ST_DEAD;
                        end
                    end
                    default: begin
                        // Re-sample the target; if u swung back, dir is unchanged.
                        w_dir_nxt   = w_new_dir;
                        w_duty_nxt  = w_new_duty;
                        w_sat_nxt   = w_new_sat;
                        w_state_nxt = ST_RUN;
                    end
                endcase
            end
        end

        // pwm is registered, so it is computed from next-cycle count and duty.
        w_pwm_nxt = en && (w_state_nxt == ST_RUN) && (w_cnt_nxt < w_duty_nxt);
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_frame_cnt <= '0;
            r_state     <= ST_RUN;
            r_duty      <= '0;
            r_dir       <= 1'b0;
            r_sat       <= 1'b0;
            r_pwm       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_frame_cnt <= w_fc_nxt;
            r_state     <= w_state_nxt;
            r_duty      <= w_duty_nxt;
            r_dir       <= w_dir_nxt;
            r_sat       <= w_sat_nxt;
            r_pwm       <= w_pwm_nxt;
        end
    end

    // Decoded from registers only, so it clears as soon as reset clears them.
    assign sample_tick = w_boundary && (r_frame_cnt == C_FC_LAST);
    assign pwm         = r_pwm;
    assign dir         = r_dir;
    assign duty        = r_duty;
    assign sat         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_drive.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_pwm_drive
//  Description : Frame-level directed bench for servo_pwm_drive. Instance A
//                uses PERIOD=10, TICK_DIV=1, MAX_DUTY=9; instance B uses
//                TICK_DIV=3. Each table row drives one whole frame and lists
//                the duty/dir/sat and per-cycle pwm/tick patterns expected in
//                that frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_drive;

    localparam int W  = 18;
    localparam int CW = 4;

    logic                 sclk;
    logic                 rst_a, rst_b;
    logic                 en_a, en_b;
    logic signed [W-1:0]  u_a, u_b;
    logic                 pwm_a, pwm_b, dir_a, dir_b, tick_a, tick_b, sat_a, sat_b;
    logic [CW-1:0]        duty_a, duty_b;

    int n_checks = 0;
    int n_errors = 0;

    servo_pwm_drive #(
        .WIDTH(W), .PERIOD(10), .CNT_WIDTH(CW), .MAX_DUTY(9), .SHIFT(0), .TICK_DIV(1)
    ) u_dut_a (
        .sclk(sclk), .rst(rst_a), .en(en_a), .u(u_a), .pwm(pwm_a), .dir(dir_a),
        .sample_tick(tick_a), .duty(duty_a), .sat(sat_a)
    );

    servo_pwm_drive #(
        .WIDTH(W), .PERIOD(10), .CNT_WIDTH(CW), .MAX_DUTY(9), .SHIFT(0), .TICK_DIV(3)
    ) u_dut_b (
        .sclk(sclk), .rst(rst_b), .en(en_b), .u(u_b), .pwm(pwm_b), .dir(dir_b),
        .sample_tick(tick_b), .duty(duty_b), .sat(sat_b)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    typedef struct {
        logic                sel;   // 0 = instance A, 1 = instance B
        logic signed [W-1:0] u0;    // u from cycle 0 of the frame
        logic signed [W-1:0] umid;  // u from cycle 5 (sampled at the boundary)
        logic                en;
        logic [CW-1:0]       duty;
        logic                dir;
        logic                sat;
        logic [9:0]          pwm;   // bit k = pwm in frame cycle k
        logic [9:0]          tick;  // bit k = sample_tick in frame cycle k
    } vec_t;

    vec_t tbl_a [0:30];
    vec_t tbl_b [0:8];

    function automatic vec_t mk(input logic sel, input int u0, input int umid,
                                input logic en, input int duty, input logic dir,
                                input logic sat, input int pwm, input int tick);
        vec_t v;
        v.sel  = sel;
        v.u0   = W'(u0);
        v.umid = W'(umid);
        v.en   = en;
        v.duty = CW'(duty);
        v.dir  = dir;
        v.sat  = sat;
        v.pwm  = 10'(pwm);
        v.tick = 10'(tick);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic signed [W-1:0] uv, input logic ev);
        if (sel) begin
            u_b  = uv;
            en_b = ev;
        end else begin
            u_a  = uv;
            en_a = ev;
        end
    endtask

    // Entered at the negedge of frame cycle 0; leaves at cycle 0 of the next frame.
    task automatic run_vec(input int idx, input vec_t v);
        logic [9:0] pw;
        logic [9:0] tk;
        drive(v.sel, v.u0, v.en);
        check("duty", idx, v.sel ? 32'(duty_b) : 32'(duty_a), 32'(v.duty));
        check("dir",  idx, v.sel ? 32'(dir_b)  : 32'(dir_a),  32'(v.dir));
        check("sat",  idx, v.sel ? 32'(sat_b)  : 32'(sat_a),  32'(v.sat));
        for (int k = 0; k < 10; k++) begin
            if (k == 5) drive(v.sel, v.umid, v.en);
            pw[k] = v.sel ? pwm_b  : pwm_a;
            tk[k] = v.sel ? tick_b : tick_a;
            @(posedge sclk);
            @(negedge sclk);
        end
        check("pwm",  idx, 32'(pw), 32'(v.pwm));
        check("tick", idx, 32'(tk), 32'(v.tick));
    endtask

    initial begin
        // Instance A: sel, u0, umid, en, duty, dir, sat, pwm, tick
        tbl_a[0]  = mk(0, 4, 4, 1, 0, 0, 0, 'h000, 'h200);           // reset frame idle
        tbl_a[1]  = mk(0, 4, 4, 1, 4, 0, 0, 'h00F, 'h200);
        tbl_a[2]  = mk(0, 300, 300, 1, 4, 0, 0, 'h00F, 'h200);
        tbl_a[3]  = mk(0, 300, 300, 1, 9, 0, 1, 'h1FF, 'h200);       // clipped
        tbl_a[4]  = mk(0, -131072, -131072, 1, 9, 0, 1, 'h1FF, 'h200);
        tbl_a[5]  = mk(0, -131072, -131072, 1, 0, 0, 0, 'h000, 'h200); // dead
        tbl_a[6]  = mk(0, 5, 5, 1, 9, 1, 1, 'h1FF, 'h200);           // most negative
        tbl_a[7]  = mk(0, 5, 5, 1, 0, 1, 0, 'h000, 'h200);           // dead
        tbl_a[8]  = mk(0, 5, 5, 1, 5, 0, 0, 'h01F, 'h200);
        tbl_a[9]  = mk(0, 5, -3, 1, 5, 0, 0, 'h01F, 'h200);          // mid-frame swap
        tbl_a[10] = mk(0, -3, -3, 1, 0, 0, 0, 'h000, 'h200);         // dead, dir held
        tbl_a[11] = mk(0, -3, -3, 1, 3, 1, 0, 'h007, 'h200);
        tbl_a[12] = mk(0, 5, 5, 1, 3, 1, 0, 'h007, 'h200);
        tbl_a[13] = mk(0, 5, 5, 1, 0, 1, 0, 'h000, 'h200);
        tbl_a[14] = mk(0, 5, 5, 1, 5, 0, 0, 'h01F, 'h200);
        tbl_a[15] = mk(0, 5, -3, 1, 5, 0, 0, 'h01F, 'h200);          // start reversal
        tbl_a[16] = mk(0, -3, 5, 1, 0, 0, 0, 'h000, 'h200);          // aborted in dead
        tbl_a[17] = mk(0, 5, 5, 1, 5, 0, 0, 'h01F, 'h200);
        tbl_a[18] = mk(0, 5, 5, 0, 5, 0, 0, 'h001, 'h200);           // en drops
        tbl_a[19] = mk(0, -7, -7, 0, 0, 0, 0, 'h000, 'h200);
        tbl_a[20] = mk(0, -7, -7, 1, 0, 0, 0, 'h000, 'h200);         // re-enable
        tbl_a[21] = mk(0, -7, -7, 1, 0, 0, 0, 'h000, 'h200);         // dead
        tbl_a[22] = mk(0, -7, -7, 1, 7, 1, 0, 'h07F, 'h200);
        tbl_a[23] = mk(0, -9, -9, 1, 7, 1, 0, 'h07F, 'h200);
        tbl_a[24] = mk(0, -10, -10, 1, 9, 1, 0, 'h1FF, 'h200);       // exactly MAX_DUTY
        tbl_a[25] = mk(0, 0, 0, 1, 9, 1, 1, 'h1FF, 'h200);           // just above
        tbl_a[26] = mk(0, 0, 0, 1, 0, 1, 0, 'h000, 'h200);           // u=0 is positive
        tbl_a[27] = mk(0, 0, 0, 1, 0, 0, 0, 'h000, 'h200);
        tbl_a[28] = mk(0, -50, -50, 1, 0, 0, 0, 'h000, 'h200);
        tbl_a[29] = mk(0, -50, -50, 1, 0, 0, 0, 'h000, 'h200);
        tbl_a[30] = mk(0, -50, -50, 1, 9, 1, 1, 'h1FF, 'h200);

        // Instance B (TICK_DIV=3), u=4 throughout, en low for frames 3-4
        tbl_b[0] = mk(1, 4, 4, 1, 0, 0, 0, 'h000, 'h000);
        tbl_b[1] = mk(1, 4, 4, 1, 4, 0, 0, 'h00F, 'h000);
        tbl_b[2] = mk(1, 4, 4, 1, 4, 0, 0, 'h00F, 'h200);
        tbl_b[3] = mk(1, 4, 4, 0, 4, 0, 0, 'h001, 'h000);
        tbl_b[4] = mk(1, 4, 4, 0, 0, 0, 0, 'h000, 'h000);
        tbl_b[5] = mk(1, 4, 4, 1, 0, 0, 0, 'h000, 'h200);
        tbl_b[6] = mk(1, 4, 4, 1, 4, 0, 0, 'h00F, 'h000);
        tbl_b[7] = mk(1, 4, 4, 1, 4, 0, 0, 'h00F, 'h000);
        tbl_b[8] = mk(1, 4, 4, 1, 4, 0, 0, 'h00F, 'h200);

        rst_a = 1'b1;
        rst_b = 1'b1;
        en_a  = 1'b1;
        en_b  = 1'b1;
        u_a   = W'(4);
        u_b   = W'(4);
        repeat (2) @(negedge sclk);

        check("rst_pwm",  0, 32'(pwm_a),  32'd0);
        check("rst_dir",  0, 32'(dir_a),  32'd0);
        check("rst_duty", 0, 32'(duty_a), 32'd0);
        check("rst_sat",  0, 32'(sat_a),  32'd0);
        check("rst_tick", 0, 32'(tick_a), 32'd0);

        rst_a = 1'b0;
        for (int i = 0; i < 31; i++) run_vec(i, tbl_a[i]);

        // Reset in cycle 6 of a frame with duty 9, dir 1, sat 1.
        for (int k = 0; k < 6; k++) begin
            @(posedge sclk);
            @(negedge sclk);
        end
        check("pre_rst_pwm", 6, 32'(pwm_a), 32'd1);
        #1 rst_a = 1'b1;
        #1;
        check("async_pwm",  6, 32'(pwm_a),  32'd0);
        check("async_dir",  6, 32'(dir_a),  32'd0);
        check("async_duty", 6, 32'(duty_a), 32'd0);
        check("async_sat",  6, 32'(sat_a),  32'd0);
        check("async_tick", 6, 32'(tick_a), 32'd0);
        @(negedge sclk);
        rst_a = 1'b0;
        run_vec(100, mk(0, -50, -50, 1, 0, 0, 0, 'h000, 'h200));

        rst_b = 1'b0;
        for (int i = 0; i < 9; i++) run_vec(200 + i, tbl_b[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
